// File: rtl/log_lut_sched_pkg.sv
// Shared types and helpers for the log LUT scheduler: fill FSM states and table depth.
package log_lut_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    function automatic int lut_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/log_lut_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or after the pointer wins; pointer moves past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[(int'(ptr_q) + k) % NUM_REQ]) begin
                any    = 1'b1;
                winner = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (any) gnt[winner] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any) ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/log_lut_sched.sv
// Scheduler for the 1R/1W log LUT RAM: round-robin read sharing, host writes,
// whole-table fill, and write-to-read forwarding so reads see post-write data.
module log_lut_sched
    import log_lut_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          wr_req,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_ack,
    input  logic                          fill_start,
    input  logic [DATA_WIDTH-1:0]         fill_val,
    output logic                          fill_busy,
    output logic                          fill_done,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr_w,
    output logic [DATA_WIDTH-1:0]         ram_din,
    output logic [ADDR_WIDTH-1:0]         ram_addr_r,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = lut_depth(ADDR_WIDTH);
    // Extra counter bit keeps the terminal index distinct from a wrapped zero.
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    logic [NUM_REQ-1:0]    gnt_raw;
    logic [IDX_W-1:0]      win;
    logic                  any;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [ADDR_WIDTH-1:0] raddr_q;

    fill_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fval_q, fval_d;

    logic [NUM_REQ-1:0]    rd_valid_q;
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] fwd_q;
    logic [DATA_WIDTH-1:0] hold_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt_raw),
        .winner  (win),
        .any     (any)
    );

    always_comb begin
        win_addr = req_addr[int'(win) * ADDR_WIDTH +: ADDR_WIDTH];
    end

    assign grant      = any & reset_n;
    assign gnt        = reset_n ? gnt_raw : '0;
    assign ram_addr_r = grant ? win_addr : raddr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fval_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fval_q  <= fval_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fval_d  = fval_q;
        case (state_q)
            IDLE: if (fill_start) begin
                state_d = FILL;
                cnt_d   = '0;
                fval_d  = fill_val;
            end
            FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Host writes own the write port only in IDLE; during FILL/DONE they stall.
    always_comb begin
        ram_we     = 1'b0;
        ram_addr_w = wr_addr;
        ram_din    = wr_data;
        wr_ack     = 1'b0;
        fill_busy  = 1'b0;
        fill_done  = 1'b0;
        case (state_q)
            IDLE: begin
                ram_we = wr_req & reset_n;
                wr_ack = wr_req & reset_n;
            end
            FILL: begin
                ram_we     = reset_n;
                ram_addr_w = cnt_q[ADDR_WIDTH-1:0];
                ram_din    = fval_q;
                fill_busy  = 1'b1;
            end
            DONE:    fill_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raddr_q    <= '0;
            rd_valid_q <= '0;
            hit_q      <= 1'b0;
            fwd_q      <= '0;
            hold_q     <= '0;
        end else begin
            if (grant) raddr_q <= win_addr;
            rd_valid_q <= gnt;
            hit_q      <= grant & ram_we & (ram_addr_w == ram_addr_r);
            fwd_q      <= ram_din;
            if (|rd_valid_q) hold_q <= rd_data;
        end
    end

    // RAM read data lands one cycle after the grant; a same-cycle write overrides it.
    assign rd_data  = (|rd_valid_q) ? (hit_q ? fwd_q : ram_dout) : hold_q;
    assign rd_valid = rd_valid_q;

endmodule
